gcn_transform_engine: RTL and testbench

GCN_TRANSFORM_ENGINE -- requirements
Module: gcn_transform_engine

---
 rtl/gcn_pkg.sv | 22 ++
 rtl/gcn_dot_product.sv | 33 +++
 rtl/gcn_transform_engine.sv | 151 +++++++++++++++
 tb/tb_gcn_transform_engine.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcn_pkg.sv
// Shared types and constants for the GCN feature/weight transform engine.
package gcn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        WAIT_W,
        ISSUE_F,
        WAIT_F,
        MAC,
        WRITE
    } gcn_state_e;

    localparam int GCN_WEIGHT_ADDRESS_BASE  = 'h0;
    localparam int GCN_FEATURE_ADDRESS_BASE = 'h200;

    // Width that holds a full-precision sum of vector_len unsigned products.
    function automatic int dot_prod_width(input int in_width, input int vector_len);
        return 2 * in_width + $clog2(vector_len);
    endfunction

endpackage

// File: rtl/gcn_dot_product.sv
// Unsigned dot product of two vectors with a registered, full-precision result.
module gcn_dot_product #(
    parameter int VECTOR_LEN = 96,
    parameter int IN_WIDTH   = 5,
    parameter int OUT_WIDTH  = 17
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                valid,
    input  logic [VECTOR_LEN-1:0][IN_WIDTH-1:0] vec_a,
    input  logic [VECTOR_LEN-1:0][IN_WIDTH-1:0] vec_b,
    output logic [OUT_WIDTH-1:0]                result
);

    logic [OUT_WIDTH-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < VECTOR_LEN; i++) begin
            sum = sum + OUT_WIDTH'(vec_a[i]) * OUT_WIDTH'(vec_b[i]);
        end
    end

    // valid is a single-cycle qualifier: result updates on the edge ending a valid cycle and holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
        end else if (valid) begin
            result <= sum;
        end
    end

endmodule

// File: rtl/gcn_transform_engine.sv
// Computes FM x WM one weight column at a time, fetching rows from an external
// fixed-latency memory, and keeps the result matrix readable by row.
module gcn_transform_engine
    import gcn_pkg::*;
#(
    parameter int FEATURE_ROWS  = 6,
    parameter int FEATURE_COLS  = 96,
    parameter int WEIGHT_COLS   = 3,
    parameter int IN_WIDTH      = 5,
    parameter int MEM_LATENCY   = 1,
    parameter int ADDRESS_WIDTH = 13,
    parameter logic [ADDRESS_WIDTH-1:0] WEIGHT_ADDRESS_BASE  = ADDRESS_WIDTH'(GCN_WEIGHT_ADDRESS_BASE),
    parameter logic [ADDRESS_WIDTH-1:0] FEATURE_ADDRESS_BASE = ADDRESS_WIDTH'(GCN_FEATURE_ADDRESS_BASE),
    localparam int DOT_PROD_WIDTH = dot_prod_width(IN_WIDTH, FEATURE_COLS),
    localparam int ROW_W          = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic [FEATURE_COLS-1:0][IN_WIDTH-1:0]      data_in,
    input  logic [ROW_W-1:0]                           read_row,
    output logic [ADDRESS_WIDTH-1:0]                   read_address,
    output logic                                       read_enable,
    output logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] FM_WM_Row,
    output logic                                       busy,
    output logic                                       done
);

    localparam int COL_W = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
    localparam logic [2:0] W_LAST = 3'(MEM_LATENCY - 1);
    // The MAC cycle doubles as the last memory-latency cycle of a feature read,
    // so WAIT_F covers only the cycles before it (none when MEM_LATENCY is 1).
    localparam logic [2:0] F_LAST = 3'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);

    gcn_state_e state, next_state;
    logic [2:0]               lat_cnt;
    logic [ROW_W-1:0]         row_idx, row_next;
    logic [COL_W-1:0]         col_idx, col_next;
    logic                     done_next;
    logic                     rd_en_next;
    logic [ADDRESS_WIDTH-1:0] addr_next;
    logic                     dp_valid;
    logic [DOT_PROD_WIDTH-1:0] dp_result;
    logic [FEATURE_COLS-1:0][IN_WIDTH-1:0] weight_q;
    logic [DOT_PROD_WIDTH-1:0] result_mem [FEATURE_ROWS][WEIGHT_COLS];

    always_comb begin
        next_state = state;
        row_next   = row_idx;
        col_next   = col_idx;
        done_next  = done;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = LOAD_W;
                    row_next   = '0;
                    col_next   = '0;
                    done_next  = 1'b0;
                end
            end
            LOAD_W:  next_state = WAIT_W;
            WAIT_W:  if (lat_cnt == W_LAST) next_state = ISSUE_F;
            ISSUE_F: next_state = (MEM_LATENCY == 1) ? MAC : WAIT_F;
            WAIT_F:  if (lat_cnt == F_LAST) next_state = MAC;
            MAC:     next_state = WRITE;
            WRITE: begin
                if (row_idx != ROW_W'(FEATURE_ROWS - 1)) begin
                    row_next   = row_idx + ROW_W'(1);
                    next_state = ISSUE_F;
                end else if (col_idx != COL_W'(WEIGHT_COLS - 1)) begin
                    row_next   = '0;
                    col_next   = col_idx + COL_W'(1);
                    next_state = LOAD_W;
                end else begin
                    next_state = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase

        // Strobe and address are registered from the upcoming state so they are
        // valid exactly during the LOAD_W / ISSUE_F cycle.
        rd_en_next = (next_state == LOAD_W) || (next_state == ISSUE_F);
        addr_next  = read_address;
        if (next_state == LOAD_W) begin
            addr_next = WEIGHT_ADDRESS_BASE + ADDRESS_WIDTH'(col_next);
        end else if (next_state == ISSUE_F) begin
            addr_next = FEATURE_ADDRESS_BASE + ADDRESS_WIDTH'(row_next);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            row_idx      <= '0;
            col_idx      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            read_enable  <= 1'b0;
            read_address <= '0;
            weight_q     <= '0;
            for (int r = 0; r < FEATURE_ROWS; r++) begin
                for (int c = 0; c < WEIGHT_COLS; c++) begin
                    result_mem[r][c] <= '0;
                end
            end
        end else begin
            state        <= next_state;
            lat_cnt      <= (next_state != state) ? 3'd0 : lat_cnt + 3'd1;
            row_idx      <= row_next;
            col_idx      <= col_next;
            busy         <= (next_state != IDLE);
            done         <= done_next;
            read_enable  <= rd_en_next;
            read_address <= addr_next;
            if (state == WAIT_W && lat_cnt == W_LAST) begin
                weight_q <= data_in;
            end
            if (state == WRITE) begin
                result_mem[row_idx][col_idx] <= dp_result;
            end
        end
    end

    assign dp_valid = (state == MAC);

    gcn_dot_product #(
        .VECTOR_LEN (FEATURE_COLS),
        .IN_WIDTH   (IN_WIDTH),
        .OUT_WIDTH  (DOT_PROD_WIDTH)
    ) u_dot_product (
        .clk    (clk),
        .reset  (reset),
        .valid  (dp_valid),
        .vec_a  (data_in),
        .vec_b  (weight_q),
        .result (dp_result)
    );

    always_comb begin
        FM_WM_Row = '0;
        if (int'(read_row) < FEATURE_ROWS) begin
            for (int c = 0; c < WEIGHT_COLS; c++) begin
                FM_WM_Row[c] = result_mem[read_row][c];
            end
        end
    end

endmodule

// File: tb/tb_gcn_transform_engine.sv
// Directed bench: default-size engine plus a MEM_LATENCY=3, 4x2 variant, each
// fed by a behavioural fixed-latency memory.
module tb_gcn_transform_engine;

    typedef logic [95:0][4:0] vec_t;

    logic clk = 1'b0;
    logic reset;
    logic start_a, start_b;
    vec_t data_in_a, data_in_b;
    logic [2:0] read_row_a;
    logic [1:0] read_row_b;
    logic [12:0] read_address_a, read_address_b;
    logic read_enable_a, read_enable_b;
    logic [2:0][16:0] FM_WM_Row_a;
    logic [1:0][16:0] FM_WM_Row_b;
    logic busy_a, busy_b, done_a, done_b;

    int vectors = 0;
    int miscompares = 0;

    vec_t wmem_a [3];
    vec_t fmem_a [6];
    vec_t wmem_b [2];
    vec_t fmem_b [4];
    vec_t pipe_a;
    vec_t pipe_b [3];
    logic [12:0] got_q[$];
    logic [12:0] exp_q[$];

    always #5 clk = ~clk;

    gcn_transform_engine dut_a (
        .clk          (clk),
        .reset        (reset),
        .start        (start_a),
        .data_in      (data_in_a),
        .read_row     (read_row_a),
        .read_address (read_address_a),
        .read_enable  (read_enable_a),
        .FM_WM_Row    (FM_WM_Row_a),
        .busy         (busy_a),
        .done         (done_a)
    );

    gcn_transform_engine #(
        .FEATURE_ROWS (4),
        .WEIGHT_COLS  (2),
        .MEM_LATENCY  (3)
    ) dut_b (
        .clk          (clk),
        .reset        (reset),
        .start        (start_b),
        .data_in      (data_in_b),
        .read_row     (read_row_b),
        .read_address (read_address_b),
        .read_enable  (read_enable_b),
        .FM_WM_Row    (FM_WM_Row_b),
        .busy         (busy_b),
        .done         (done_b)
    );

    function automatic vec_t fetch_a(input logic [12:0] addr);
        int idx;
        idx = int'(addr);
        if (idx >= 'h200) return (idx - 'h200 < 6) ? fmem_a[idx - 'h200] : '0;
        return (idx < 3) ? wmem_a[idx] : '0;
    endfunction

    function automatic vec_t fetch_b(input logic [12:0] addr);
        int idx;
        idx = int'(addr);
        if (idx >= 'h200) return (idx - 'h200 < 4) ? fmem_b[idx - 'h200] : '0;
        return (idx < 2) ? wmem_b[idx] : '0;
    endfunction

    // Memory data appears MEM_LATENCY cycles after the strobe cycle, zero otherwise.
    always @(posedge clk) begin
        pipe_a    <= read_enable_a ? fetch_a(read_address_a) : '0;
        pipe_b[0] <= read_enable_b ? fetch_b(read_address_b) : '0;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
        if (read_enable_b) got_q.push_back(read_address_b);
    end

    assign data_in_a = pipe_a;
    assign data_in_b = pipe_b[2];

    task automatic fill_a(input int wval, input int fval_ramp, input int fval_const);
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < 96; k++) wmem_a[c][k] = 5'(wval);
        for (int r = 0; r < 6; r++)
            for (int k = 0; k < 96; k++) fmem_a[r][k] = fval_ramp ? 5'(r + 1) : 5'(fval_const);
    endtask

    task automatic run_a(input int pulse_at, input int reset_at, output int cyc);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 0;
        while (busy_a && cyc < 500) begin
            cyc++;
            start_a = (cyc == pulse_at);
            if (cyc == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                start_a = 1'b0;
                return;
            end
            @(negedge clk);
        end
        start_a = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start_a = 1'b1;
        start_b = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        read_row_a = 3'd0;
        #1;
        vectors++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags busy=%b done=%b exp busy=0 done=0", busy_a, done_a);
        end
        vectors++;
        if (read_enable_a !== 1'b0 || read_address_a !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_read re=%b addr=%h exp re=0 addr=0000", read_enable_a, read_address_a);
        end
        vectors++;
        if (FM_WM_Row_a !== '0) begin
            miscompares++;
            $display("FAIL reset_row0 got=%h exp=0", FM_WM_Row_a);
        end
        @(negedge clk);
        vectors++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_start_ignored busy_a=%b busy_b=%b exp 0 0", busy_a, busy_b);
        end
    endtask

    task automatic test_ramp();
        int cyc;
        logic [2:0][16:0] exp_row;
        fill_a(1, 1, 0);
        run_a(0, 0, cyc);
        vectors++;
        if (cyc !== 60) begin
            miscompares++;
            $display("FAIL ramp_busy_cycles got=%0d exp=60", cyc);
        end
        vectors++;
        if (busy_a !== 1'b0 || done_a !== 1'b1) begin
            miscompares++;
            $display("FAIL ramp_done busy=%b done=%b exp busy=0 done=1", busy_a, done_a);
        end
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 3; c++) exp_row[c] = 17'(96 * (r + 1));
            read_row_a = 3'(r);
            #1;
            vectors++;
            if (FM_WM_Row_a !== exp_row) begin
                miscompares++;
                $display("FAIL ramp_row%0d got=%h exp=%h", r, FM_WM_Row_a, exp_row);
            end
        end
    endtask

    task automatic test_max_overwrite();
        int cyc;
        logic [2:0][16:0] exp_row;
        fill_a(31, 0, 31);
        run_a(0, 0, cyc);
        vectors++;
        if (cyc !== 60) begin
            miscompares++;
            $display("FAIL max_busy_cycles got=%0d exp=60", cyc);
        end
        for (int c = 0; c < 3; c++) exp_row[c] = 17'd92256;
        for (int r = 0; r < 6; r++) begin
            read_row_a = 3'(r);
            #1;
            vectors++;
            if (FM_WM_Row_a !== exp_row) begin
                miscompares++;
                $display("FAIL max_row%0d got=%h exp=%h", r, FM_WM_Row_a, exp_row);
            end
        end
        for (int r = 6; r < 8; r++) begin
            read_row_a = 3'(r);
            #1;
            vectors++;
            if (FM_WM_Row_a !== '0) begin
                miscompares++;
                $display("FAIL out_of_range_row%0d got=%h exp=0", r, FM_WM_Row_a);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        logic [2:0][16:0] exp_row;
        repeat (3) @(negedge clk);
        vectors++;
        if (done_a !== 1'b1) begin
            miscompares++;
            $display("FAIL done_level_hold got=%b exp=1", done_a);
        end
        fill_a(1, 1, 0);
        run_a(10, 0, cyc);
        vectors++;
        if (cyc !== 60) begin
            miscompares++;
            $display("FAIL restart_busy_cycles got=%0d exp=60", cyc);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (busy_a !== 1'b0 || done_a !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_no_rerun busy=%b done=%b exp busy=0 done=1", busy_a, done_a);
        end
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 3; c++) exp_row[c] = 17'(96 * (r + 1));
            read_row_a = 3'(r);
            #1;
            vectors++;
            if (FM_WM_Row_a !== exp_row) begin
                miscompares++;
                $display("FAIL restart_row%0d got=%h exp=%h", r, FM_WM_Row_a, exp_row);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        logic [2:0][16:0] exp_row;
        fill_a(31, 0, 31);
        run_a(0, 25, cyc);
        vectors++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_flags busy=%b done=%b exp busy=0 done=0", busy_a, done_a);
        end
        for (int r = 0; r < 8; r++) begin
            read_row_a = 3'(r);
            #1;
            vectors++;
            if (FM_WM_Row_a !== '0) begin
                miscompares++;
                $display("FAIL midreset_row%0d got=%h exp=0", r, FM_WM_Row_a);
            end
        end
        run_a(0, 0, cyc);
        vectors++;
        if (cyc !== 60) begin
            miscompares++;
            $display("FAIL postreset_busy_cycles got=%0d exp=60", cyc);
        end
        for (int c = 0; c < 3; c++) exp_row[c] = 17'd92256;
        for (int r = 0; r < 6; r++) begin
            read_row_a = 3'(r);
            #1;
            vectors++;
            if (FM_WM_Row_a !== exp_row) begin
                miscompares++;
                $display("FAIL postreset_row%0d got=%h exp=%h", r, FM_WM_Row_a, exp_row);
            end
        end
    endtask

    task automatic test_latency3();
        int cyc;
        int sum;
        logic [1:0][16:0] exp_row [4];
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < 96; k++) wmem_b[c][k] = 5'($urandom_range(0, 31));
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 96; k++) fmem_b[r][k] = 5'($urandom_range(0, 31));
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 2; c++) begin
                sum = 0;
                for (int k = 0; k < 96; k++) sum += int'(fmem_b[r][k]) * int'(wmem_b[c][k]);
                exp_row[r][c] = 17'(sum);
            end
        end
        exp_q = '{13'h000, 13'h200, 13'h201, 13'h202, 13'h203,
                  13'h001, 13'h200, 13'h201, 13'h202, 13'h203};
        got_q.delete();
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cyc = 0;
        while (busy_b && cyc < 500) begin
            cyc++;
            @(negedge clk);
        end
        vectors++;
        if (cyc !== 48) begin
            miscompares++;
            $display("FAIL lat3_busy_cycles got=%0d exp=48", cyc);
        end
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL lat3_addr_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL lat3_addr%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        vectors++;
        if (read_enable_b !== 1'b0 || read_address_b !== 13'h203 || done_b !== 1'b1) begin
            miscompares++;
            $display("FAIL lat3_idle re=%b addr=%h done=%b exp re=0 addr=0203 done=1",
                     read_enable_b, read_address_b, done_b);
        end
        for (int r = 0; r < 4; r++) begin
            read_row_b = 2'(r);
            #1;
            vectors++;
            if (FM_WM_Row_b !== exp_row[r]) begin
                miscompares++;
                $display("FAIL lat3_row%0d got=%h exp=%h", r, FM_WM_Row_b, exp_row[r]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        read_row_a = 3'd0;
        read_row_b = 2'd0;
        test_reset();
        test_ramp();
        test_max_overwrite();
        test_start_while_busy();
        test_reset_mid_run();
        test_latency3();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
